// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: AXI-Stream style word channel carrying two
// seven-segment digit codes (s_data[0] = ones, s_data[1] = tens).
interface seg_display_mux_if;
   logic            s_valid;
   logic            s_ready;
   logic [1:0][6:0] s_data;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux: holds the last accepted two-digit word and drives a
// two-digit multiplexed LED display with per-slot dead time.
// Ports: clk, rstn (async, active-low), s_axis (slave word channel),
// seg[6:0] (g..a) and an[1:0] (an[0] = ones), polarity set by ACTIVE_LOW.
module seg_display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD        = 500,
   parameter bit BLANK_LZ    = 1'b1,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   seg_display_mux_if.slave  s_axis,
   output logic [6:0]        seg,
   output logic [1:0]        an
);

   localparam int              CW        = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]   DEAD_C    = CW'(DEAD);
   localparam logic [6:0]      ZERO_CODE = 7'b0111111;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SHOW = 1'b1;

   logic [0:0]      state;
   logic [1:0][6:0] disp;
   logic [CW-1:0]   cnt;
   logic            d;

   logic            last;
   logic            lit;
   logic [1:0]      an_h;
   logic [6:0]      seg_h;

   assign last = (cnt == CNT_MAX);

   // Words land only on the final cycle of a frame so a pair is never
   // shown half-old, half-new.
   assign s_axis.s_ready = (state == IDLE) || (d && last);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         disp  <= '0;
         cnt   <= '0;
         d     <= 1'b0;
      end else if (state == IDLE) begin
         if (s_axis.s_valid) begin
            state <= SHOW;
            disp  <= s_axis.s_data;
            cnt   <= '0;
            d     <= 1'b0;
         end
      end else begin
         if (last) begin
            cnt <= '0;
            d   <= ~d;
            if (d && s_axis.s_valid)
               disp <= s_axis.s_data;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      lit   = 1'b0;
      an_h  = 2'b00;
      seg_h = 7'b0;
      lit   = (state == SHOW)
            && !(cnt < DEAD_C)
            && !(d && BLANK_LZ && (disp[1] == ZERO_CODE));
      if (lit) begin
         an_h  = d ? 2'b10 : 2'b01;
         seg_h = disp[d];
      end
   end

   assign seg = ACTIVE_LOW ? ~seg_h : seg_h;
   assign an  = ACTIVE_LOW ? ~an_h  : an_h;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: scoreboard bench; a frame-position model pushes the
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_seg_display_mux;

   localparam int RD = 4;
   localparam int DT = 1;
   localparam logic [6:0] ZERO = 7'b0111111;

   logic clk;
   logic rstn;
   logic tb_valid;
   logic [1:0][6:0] tb_data;

   logic [6:0] seg0, seg1;
   logic [1:0] an0, an1;

   int n_chk;
   int n_fail;

   seg_display_mux_if if0 ();
   seg_display_mux_if if1 ();

   assign if0.s_valid = tb_valid;
   assign if0.s_data  = tb_data;
   assign if1.s_valid = tb_valid;
   assign if1.s_data  = tb_data;

   seg_display_mux #(
      .REFRESH_DIV(RD), .DEAD(DT), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)
   ) dut0 (
      .clk(clk), .rstn(rstn), .s_axis(if0.slave), .seg(seg0), .an(an0)
   );

   seg_display_mux #(
      .REFRESH_DIV(RD), .DEAD(DT), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)
   ) dut1 (
      .clk(clk), .rstn(rstn), .s_axis(if1.slave), .seg(seg1), .an(an1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   // Model: idle flag, position 0..7 within the frame, held word.
   bit              m_idle;
   int              m_pos;
   logic [1:0][6:0] m_disp;
   bit              m_acc;

   logic [19:0] q[$];

   function automatic logic [9:0] exp_out(input bit blank_lz);
      int slot;
      int c;
      logic [1:0] a;
      logic [6:0] s;
      logic r;
      a = 2'b00;
      s = 7'b0;
      r = 1'b1;
      if (!m_idle) begin
         slot = m_pos / RD;
         c    = m_pos % RD;
         r    = (m_pos == 2 * RD - 1);
         if (c >= DT && !(slot == 1 && blank_lz && m_disp[1] == ZERO)) begin
            a = (slot == 1) ? 2'b10 : 2'b01;
            s = m_disp[slot];
         end
      end
      return {r, ~a, ~s};
   endfunction

   task automatic push_exp();
      q.push_back({exp_out(1'b1), exp_out(1'b0)});
   endtask

   task automatic cycle();
      @(posedge clk);
      m_acc = 1'b0;
      if (!rstn) begin
         m_idle = 1'b1;
         m_pos  = 0;
         m_disp = '0;
      end else if (m_idle) begin
         if (tb_valid) begin
            m_idle = 1'b0;
            m_pos  = 0;
            m_disp = tb_data;
            m_acc  = 1'b1;
         end
      end else begin
         if (m_pos == 2 * RD - 1 && tb_valid) begin
            m_disp = tb_data;
            m_acc  = 1'b1;
         end
         m_pos = (m_pos + 1) % (2 * RD);
      end
      push_exp();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Hold the word on the channel until the model sees it taken.
   task automatic send(input logic [1:0][6:0] w);
      bit done;
      done     = 1'b0;
      tb_valid = 1'b1;
      tb_data  = w;
      for (int i = 0; i < 3 * RD && !done; i++) begin
         cycle();
         done = m_acc;
      end
      chk("accept_timeout", 16'(done), 16'd1);
      tb_valid = 1'b0;
      tb_data  = '0;
   endtask

   always @(negedge clk) begin
      logic [19:0] e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("rdy0", 16'(if0.s_ready), 16'(e[19]));
         chk("an0",  16'(an0),         16'(e[18:17]));
         chk("seg0", 16'(seg0),        16'(e[16:10]));
         chk("rdy1", 16'(if1.s_ready), 16'(e[9]));
         chk("an1",  16'(an1),         16'(e[8:7]));
         chk("seg1", 16'(seg1),        16'(e[6:0]));
      end
   end

   initial begin
      bit hit;
      n_chk    = 0;
      n_fail   = 0;
      tb_valid = 1'b0;
      tb_data  = '0;
      m_idle   = 1'b1;
      m_pos    = 0;
      m_disp   = '0;
      rstn     = 1'b0;
      #1;
      chk("rst_seg", 16'(seg0), 16'h7F);
      chk("rst_an",  16'(an0),  16'h3);
      chk("rst_rdy", 16'(if0.s_ready), 16'h1);
      run(3);
      rstn = 1'b1;
      run(20);

      // value 22, one accepted cycle
      send({7'b1011011, 7'b1011011});
      run(2 * RD * 2);

      // backpressure from mid-frame
      run(3);
      send({7'b1011011, 7'b1101101});
      run(2 * RD + 2);

      // leading-zero tens
      send({ZERO, 7'b0000110});
      run(2 * RD * 2);

      // hold for 5 frames
      run(2 * RD * 5);

      // reset at d=1, cnt=2
      hit = 1'b0;
      for (int i = 0; i < 4 * RD && !hit; i++) begin
         cycle();
         hit = (m_pos == RD + 2);
      end
      chk("pos_timeout", 16'(hit), 16'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("mid_rst_seg", 16'(seg0), 16'h7F);
      chk("mid_rst_an",  16'(an0),  16'h3);
      chk("mid_rst_rdy", 16'(if0.s_ready), 16'h1);
      q.delete();
      m_idle = 1'b1;
      m_pos  = 0;
      m_disp = '0;
      push_exp();
      run(2);
      rstn = 1'b1;
      run(3);
      send({7'b1001111, 7'b1100110});
      run(2 * RD * 2);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
